keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 33 +++
 rtl/keypad_scanner.sv | 147 ++++++++++++++
 tb/tb_keypad_scanner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// =============================================================================
// Module   : keypad_scanner_pkg
// Purpose  : Shared types and constants for the 4x4 keypad scanner.
// Revision : 1.0
// =============================================================================
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESSED      = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } state_t;

    // Nibble {row,col} holds the legend printed on that key.
    localparam logic [63:0] c_key_map = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] col_drive(input logic [1:0] col);
        logic [3:0] pattern;
        case (col)
            2'd0:    pattern = 4'b1110;
            2'd1:    pattern = 4'b1101;
            2'd2:    pattern = 4'b1011;
            default: pattern = 4'b0111;
        endcase
        return pattern;
    endfunction

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return c_key_map[{row, col, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// =============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for slow asynchronous inputs (rows, buttons).
// Revision : 1.0
// =============================================================================
module sync_2ff #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// =============================================================================
// Module   : keypad_scanner
// Purpose  : Column-scans a 4x4 keypad, debounces whole scans, emits key events.
// Revision : 1.0
// =============================================================================
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int                    c_dwell_w    = $clog2(SCAN_DIV);
    localparam int                    c_stable_w   = $clog2(DEBOUNCE_SCANS);
    localparam logic [c_dwell_w-1:0]  c_dwell_last = c_dwell_w'(SCAN_DIV - 1);
    localparam logic [c_stable_w-1:0] c_stable_max = c_stable_w'(DEBOUNCE_SCANS - 1);

    logic [3:0]            w_rows_sync;
    logic [c_dwell_w-1:0]  r_dwell;
    logic [1:0]            r_col;
    logic [15:0]           r_snap;
    logic [15:0]           r_prev;
    logic [c_stable_w-1:0] r_stable;
    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_key_idx;
    logic [3:0]            r_key_code;
    logic                  r_key_valid;

    logic                  w_sample;
    logic                  w_scan_end;
    logic [15:0]           w_snap_next;
    logic [c_stable_w-1:0] w_stable_next;
    logic                  w_accept;
    logic                  w_one_key;
    logic [3:0]            w_idx;
    logic                  w_press;

    sync_2ff #(
        .WIDTH       (4),
        .RESET_VALUE (4'b1111)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (w_rows_sync)
    );

    assign w_sample   = (r_dwell == c_dwell_last);
    assign w_scan_end = w_sample && (r_col == 2'd3);

    // Snapshot bit 4*col+row is set when that key is pressed.
    always_comb begin
        w_snap_next = r_snap;
        w_snap_next[{r_col, 2'b00} +: 4] = ~w_rows_sync;
    end

    always_comb begin
        w_stable_next = '0;
        if (w_snap_next == r_prev) begin
            w_stable_next = (r_stable == c_stable_max) ? r_stable : r_stable + c_stable_w'(1);
        end
    end

    assign w_accept  = w_scan_end && (w_stable_next == c_stable_max);
    assign w_one_key = $onehot(w_snap_next);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (w_snap_next[i]) w_idx = 4'(i);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_press      = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_one_key) begin
                        w_state_next = ST_PRESSED;
                        w_press      = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (w_snap_next == '0)
                        w_state_next = ST_IDLE;
                    else if (!(w_one_key && (w_idx == r_key_idx)))
                        w_state_next = ST_WAIT_RELEASE;
                end
                ST_WAIT_RELEASE: begin
                    if (w_snap_next == '0) w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dwell     <= '0;
            r_col       <= '0;
            r_snap      <= '0;
            r_prev      <= '0;
            r_stable    <= '0;
            r_state     <= ST_IDLE;
            r_key_idx   <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= w_press;
            r_state     <= w_state_next;
            if (w_sample) begin
                r_dwell <= '0;
                r_col   <= r_col + 2'd1;
                r_snap  <= w_snap_next;
            end else begin
                r_dwell <= r_dwell + c_dwell_w'(1);
            end
            if (w_scan_end) begin
                r_prev   <= w_snap_next;
                r_stable <= w_stable_next;
            end
            if (w_press) begin
                r_key_idx  <= w_idx;
                r_key_code <= key_lookup(w_idx[1:0], w_idx[3:2]);
            end
        end
    end

    assign col_n     = col_drive(r_col);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = (r_state == ST_PRESSED);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// =============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Randomized self-checking bench with a keypad model and scan-level reference.
// Revision : 1.0
// =============================================================================
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // Physical keypad: bit 4*row+col set means that key is held down.
    logic [15:0] pressed = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;
    logic [3:0] last_code = '0;

    // Reference model state
    int          m_cyc;
    logic [15:0] m_scan;
    logic [15:0] snaps[$];
    logic [15:0] hist_q[$];
    int          m_mode;          // 0 idle, 1 pressed, 2 wait release
    logic [15:0] m_key_snap;
    logic [3:0]  m_code;
    logic        m_valid;

    int key_tbl[4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) row_n[r] = ~|(pressed[4*r +: 4] & ~col_n);
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] expected);
        n_tests++;
        if (got !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, expected, $time);
        end
    endtask

    function automatic logic [15:0] key_bit(input int r, input int c);
        logic [15:0] one = 16'h0001;
        return one << (4*r + c);
    endfunction

    task automatic model_reset();
        m_cyc = 0;
        m_scan = '0;
        snaps.delete();
        snaps.push_back(16'h0000);
        hist_q.delete();
        m_mode = 0;
        m_key_snap = '0;
        m_code = '0;
        m_valid = 1'b0;
    endtask

    task automatic apply_rules(input logic [15:0] s);
        int n = $countones(s);
        case (m_mode)
            0: if (n == 1) begin
                for (int i = 0; i < 16; i++) begin
                    if (s[i]) m_code = 4'(key_tbl[i % 4][i / 4]);
                end
                m_valid = 1'b1;
                m_key_snap = s;
                m_mode = 1;
            end
            1: begin
                if (s == 16'h0) m_mode = 0;
                else if (s != m_key_snap) m_mode = 2;
            end
            default: if (s == 16'h0) m_mode = 0;
        endcase
    endtask

    // Reference for one clock edge: which column is sampled, what rows were seen.
    task automatic model_edge();
        int c = (m_cyc / SCAN_DIV) % 4;
        logic [15:0] h = '0;
        bit acc;
        m_valid = 1'b0;
        if (m_cyc % SCAN_DIV == SCAN_DIV - 1) begin
            if (hist_q.size() == 3) h = hist_q[0];
            for (int r = 0; r < 4; r++) m_scan[4*c + r] = h[4*r + c];
            if (c == 3) begin
                snaps.push_back(m_scan);
                if (snaps.size() > DEBOUNCE_SCANS) void'(snaps.pop_front());
                acc = (snaps.size() == DEBOUNCE_SCANS);
                for (int i = 1; i < snaps.size(); i++) if (snaps[i] != snaps[0]) acc = 0;
                if (acc) apply_rules(m_scan);
            end
        end
        m_cyc++;
    endtask

    task automatic tick();
        logic [3:0] one = 4'b0001;
        logic [3:0] exp_col;
        hist_q.push_back(pressed);
        if (hist_q.size() > 3) void'(hist_q.pop_front());
        @(posedge clk);
        model_edge();
        exp_col = ~(one << ((m_cyc / SCAN_DIV) % 4));
        #1;
        check_val("col_n", 16'(col_n), 16'(exp_col));
        check_val("key_valid", 16'(key_valid), 16'(m_valid));
        check_val("key_code", 16'(key_code), 16'(m_code));
        check_val("key_held", 16'(key_held), 16'(m_mode == 1));
        if (key_valid === 1'b1) begin
            pulse_cnt++;
            last_code = key_code;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int sel;
        int a;
        int b;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_col_n", 16'(col_n), 16'h000E);
        check_val("rst_key_code", 16'(key_code), 16'h0000);
        check_val("rst_key_valid", 16'(key_valid), 16'h0000);
        check_val("rst_key_held", 16'(key_held), 16'h0000);
        reset = 1'b0;
        model_reset();

        run(80);
        check_val("idle_pulses", 16'(pulse_cnt), 16'd0);

        pulse_cnt = 0;
        pressed = key_bit(1, 2);
        run(128);
        check_val("k6_pulses", 16'(pulse_cnt), 16'd1);
        check_val("k6_code", 16'(last_code), 16'h0006);
        check_val("k6_held", 16'(key_held), 16'h0001);
        pressed = '0;
        run(96);
        check_val("k6_released", 16'(key_held), 16'h0000);

        pulse_cnt = 0;
        pressed = key_bit(1, 1); run(20);
        pressed = '0;            run(20);
        pressed = key_bit(1, 1); run(20);
        check_val("bounce_no_pulse", 16'(pulse_cnt), 16'd0);
        run(100);
        check_val("k5_pulses", 16'(pulse_cnt), 16'd1);
        check_val("k5_code", 16'(last_code), 16'h0005);
        pressed = '0;
        run(96);

        pulse_cnt = 0;
        pressed = key_bit(0, 0);                  run(96);
        pressed = key_bit(0, 0) | key_bit(3, 3);  run(96);
        check_val("two_key_held", 16'(key_held), 16'h0000);
        pressed = key_bit(0, 0);                  run(96);
        check_val("k1_only_pulses", 16'(pulse_cnt), 16'd1);
        pressed = '0;                             run(96);
        pressed = key_bit(3, 3);                  run(96);
        check_val("kD_pulses", 16'(pulse_cnt), 16'd2);
        check_val("kD_code", 16'(last_code), 16'h000D);
        pressed = '0;                             run(96);

        pulse_cnt = 0;
        pressed = key_bit(3, 0) | key_bit(3, 1);  run(96);
        check_val("dual_no_pulse", 16'(pulse_cnt), 16'd0);
        check_val("dual_code_kept", 16'(key_code), 16'h000D);
        pressed = '0;                             run(96);

        pressed = key_bit(2, 2);                  run(96);
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst_col_n", 16'(col_n), 16'h000E);
        check_val("mid_rst_held", 16'(key_held), 16'h0000);
        check_val("mid_rst_code", 16'(key_code), 16'h0000);
        check_val("mid_rst_valid", 16'(key_valid), 16'h0000);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_val("in_rst_valid", 16'(key_valid), 16'h0000);
        end
        reset = 1'b0;
        model_reset();
        pulse_cnt = 0;
        run(96);
        check_val("k9_after_rst_pulses", 16'(pulse_cnt), 16'd1);
        check_val("k9_after_rst_code", 16'(last_code), 16'h0009);
        pressed = '0;
        run(96);

        repeat (40) begin
            sel = $urandom_range(0, 9);
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            if (sel < 4)      pressed = '0;
            else if (sel < 8) pressed = key_bit(a / 4, a % 4);
            else              pressed = key_bit(a / 4, a % 4) | key_bit(b / 4, b % 4);
            run($urandom_range(3, 70));
        end
        pressed = '0;
        run(96);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
